// File: rtl/mmio_uart_tx_if.sv
// Processor data-port bus for the memory-mapped UART transmitter.
// Master is the processor side, slave is the peripheral.
`timescale 1ns/1ps
interface mmio_uart_tx_if;
    logic [31:0] ip_data_addr;
    logic        ip_data_wr;
    logic [3:0]  ip_data_mask;
    logic [31:0] ip_data_from_proc;
    logic        ip_data_rd;
    logic        op_sel;
    logic        op_data_valid;
    logic [31:0] op_data_to_proc;

    modport master (
        output ip_data_addr,
        output ip_data_wr,
        output ip_data_mask,
        output ip_data_from_proc,
        output ip_data_rd,
        input  op_sel,
        input  op_data_valid,
        input  op_data_to_proc
    );

    modport slave (
        input  ip_data_addr,
        input  ip_data_wr,
        input  ip_data_mask,
        input  ip_data_from_proc,
        input  ip_data_rd,
        output op_sel,
        output op_data_valid,
        output op_data_to_proc
    );
endinterface

// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter with a TX FIFO,
// programmable bit period and a status register.
`timescale 1ns/1ps
module mmio_uart_tx #(
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0050,
    parameter int          FIFO_DEPTH  = 8,
    parameter logic [15:0] DEFAULT_DIV = 16'd868
) (
    input  logic         clk,
    input  logic         reset,
    mmio_uart_tx_if.slave bus,
    output logic         op_uart_tx
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] DEPTH_CNT = (AW+1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_t;

    state_t      state;
    logic [7:0]  mem [FIFO_DEPTH];
    logic [AW:0] wptr;
    logic [AW:0] rptr;
    logic [AW:0] count;
    logic        empty;
    logic        full;
    logic        overflow;
    logic [15:0] div;
    logic [15:0] bit_load;
    logic [15:0] cnt;
    logic [2:0]  bit_idx;
    logic [7:0]  shreg;
    logic [7:0]  head;
    logic        busy;
    logic        sel;
    logic        wr_en;
    logic [1:0]  offs;
    logic        push_req;
    logic        push_ok;
    logic        pop;
    logic        ovf_clr;
    logic        div_wr;
    logic [31:0] status;
    logic [31:0] rdata;
    logic        unused;

    assign unused = ^{bus.ip_data_addr[1:0], bus.ip_data_mask[3:2],
                      bus.ip_data_from_proc[31:16]};

    // Address decode and register strobes
    assign offs     = bus.ip_data_addr[3:2];
    assign sel      = bus.ip_data_addr[31:4] == BASE_ADDR[31:4];
    assign wr_en    = sel & bus.ip_data_wr;
    assign push_req = wr_en && offs == 2'd0 && bus.ip_data_mask[0];
    assign ovf_clr  = wr_en && offs == 2'd1 && bus.ip_data_mask[0]
                      && bus.ip_data_from_proc[3];
    assign div_wr   = wr_en && offs == 2'd2;

    assign bus.op_sel        = sel;
    assign bus.op_data_valid = sel & bus.ip_data_rd;

    // FIFO status; the byte in the shift register is not counted
    assign count = wptr - rptr;
    assign empty = wptr == rptr;
    assign full  = count == DEPTH_CNT;
    assign head  = mem[rptr[AW-1:0]];
    assign busy  = state != IDLE;

    // Pop when idle or when a stop bit finishes, giving back-to-back frames
    assign pop = !empty &&
                 (state == IDLE || (state == STOP && cnt == 16'd0));
    // A full FIFO still accepts a byte if a slot frees this cycle
    assign push_ok = push_req && (!full || pop);

    // Divisor of zero is treated as one cycle per bit
    assign bit_load = (div == 16'd0) ? 16'd0 : div - 16'd1;

    assign status = {28'b0, overflow, busy, empty, full};

    // Combinational register read mux
    always_comb begin
        rdata = '0;
        unique case (offs)
            2'd0, 2'd1: rdata = status;
            2'd2:       rdata = {16'b0, div};
            default:    rdata = '0;
        endcase
    end

    assign bus.op_data_to_proc = sel ? rdata : '0;

    // FIFO storage; contents are don't-care while pointers are reset
    always_ff @(posedge clk) begin
        if (push_ok) mem[wptr[AW-1:0]] <= bus.ip_data_from_proc[7:0];
    end

    // FIFO pointers and sticky overflow flag (set beats clear)
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wptr     <= '0;
            rptr     <= '0;
            overflow <= 1'b0;
        end else begin
            if (push_ok) wptr <= wptr + 1'b1;
            if (pop)     rptr <= rptr + 1'b1;
            if (push_req && !push_ok) overflow <= 1'b1;
            else if (ovf_clr)         overflow <= 1'b0;
        end
    end

    // Divisor register with per-byte write enables
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div <= DEFAULT_DIV;
        end else if (div_wr) begin
            if (bus.ip_data_mask[0]) div[7:0]  <= bus.ip_data_from_proc[7:0];
            if (bus.ip_data_mask[1]) div[15:8] <= bus.ip_data_from_proc[15:8];
        end
    end

    // Serialiser FSM; tx is registered one cycle behind the state
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            op_uart_tx <= 1'b1;
            shreg      <= '0;
            bit_idx    <= '0;
            cnt        <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    op_uart_tx <= 1'b1;
                    if (pop) begin
                        shreg <= head;
                        cnt   <= bit_load;
                        state <= START;
                    end
                end
                START: begin
                    op_uart_tx <= 1'b0;
                    if (cnt == 16'd0) begin
                        cnt     <= bit_load;
                        bit_idx <= '0;
                        state   <= DATA;
                    end else begin
                        cnt <= cnt - 16'd1;
                    end
                end
                DATA: begin
                    op_uart_tx <= shreg[0];
                    if (cnt == 16'd0) begin
                        cnt   <= bit_load;
                        shreg <= {1'b0, shreg[7:1]};
                        if (bit_idx == 3'd7) state <= STOP;
                        else bit_idx <= bit_idx + 3'd1;
                    end else begin
                        cnt <= cnt - 16'd1;
                    end
                end
                STOP: begin
                    op_uart_tx <= 1'b1;
                    if (cnt == 16'd0) begin
                        if (pop) begin
                            shreg <= head;
                            cnt   <= bit_load;
                            state <= START;
                        end else begin
                            state <= IDLE;
                        end
                    end else begin
                        cnt <= cnt - 16'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mmio_uart_tx.sv
// Self-checking bench for mmio_uart_tx: directed register/timing
// cases plus randomised traffic decoded by a line monitor.
`timescale 1ns/1ps
module tb_mmio_uart_tx;
    localparam logic [31:0] BASE = 32'h0000_0050;

    logic clk = 1'b0;
    logic reset;
    logic tx;

    mmio_uart_tx_if bus();

    mmio_uart_tx #(
        .BASE_ADDR(BASE),
        .FIFO_DEPTH(8),
        .DEFAULT_DIV(16'd868)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus),
        .op_uart_tx(tx)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    bit mon_en = 1'b0;
    int mon_div = 1;
    logic [7:0] exp_q[$];
    int frame_starts[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic bus_idle();
        bus.ip_data_addr      = '0;
        bus.ip_data_wr        = 1'b0;
        bus.ip_data_rd        = 1'b0;
        bus.ip_data_mask      = '0;
        bus.ip_data_from_proc = '0;
    endtask

    task automatic wr(input logic [3:0] off, input logic [31:0] d,
                      input logic [3:0] m);
        @(negedge clk);
        bus.ip_data_addr      = BASE + {28'b0, off};
        bus.ip_data_from_proc = d;
        bus.ip_data_mask      = m;
        bus.ip_data_wr        = 1'b1;
        @(negedge clk);
        bus.ip_data_wr        = 1'b0;
    endtask

    task automatic rd(input logic [3:0] off, output logic [31:0] d);
        @(negedge clk);
        bus.ip_data_addr = BASE + {28'b0, off};
        bus.ip_data_rd   = 1'b1;
        #1;
        d = bus.op_data_to_proc;
        bus.ip_data_rd   = 1'b0;
    endtask

    task automatic skip(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_idle(input string tag, input int limit);
        logic [31:0] s;
        int n;
        n = 0;
        do begin
            rd(4'h4, s);
            n++;
        end while (s[2:0] != 3'b010 && n < limit);
        chk(tag, 64'(s[2:0]), 64'(3'b010));
        repeat (2) @(posedge clk);
    endtask

    // Line monitor: decodes 8N1 frames at mon_div cycles per bit
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (mon_en && !reset && tx === 1'b0) begin : frame
                int d;
                logic [7:0] b;
                d = mon_div;
                frame_starts.push_back(cyc);
                skip(d / 2);
                chk("mon_start", 64'(tx), 64'(0));
                for (int i = 0; i < 8; i++) begin
                    skip(d);
                    b[i] = tx;
                end
                skip(d);
                chk("mon_stop", 64'(tx), 64'(1));
                if (exp_q.size() == 0)
                    chk("mon_extra_frame", 64'(b), 64'hFFFF);
                else
                    chk("mon_byte", 64'(b), 64'(exp_q.pop_front()));
                skip(d - d / 2 - 1);
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog checks=%0d", checks);
        failures++;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] s;
        logic [39:0] obs;
        logic [39:0] expv;
        logic [9:0]  fr;
        logic [7:0]  b;
        int d;
        int n;

        bus_idle();
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_tx", 64'(tx), 64'(1));
        @(negedge clk);
        reset = 1'b0;

        rd(4'h4, s);
        chk("rst_status", 64'(s), 64'h2);
        rd(4'h8, s);
        chk("rst_div", 64'(s), 64'd868);
        rd(4'h0, s);
        chk("txdata_reads_status", 64'(s), 64'h2);
        rd(4'hC, s);
        chk("reserved_rd", 64'(s), 64'h0);

        @(negedge clk);
        bus.ip_data_addr = 32'h0000_0060;
        bus.ip_data_rd   = 1'b1;
        #1;
        chk("unsel_sel", 64'(bus.op_sel), 64'(0));
        chk("unsel_data", 64'(bus.op_data_to_proc), 64'h0);
        chk("unsel_valid", 64'(bus.op_data_valid), 64'(0));
        bus.ip_data_addr = BASE + 32'h4;
        #1;
        chk("sel_valid", 64'(bus.op_data_valid), 64'(1));
        bus.ip_data_rd = 1'b0;

        // Byte-lane divisor write, then exact 0x55 waveform at DIV=4
        wr(4'h8, 32'h1234_AB00, 4'b0010);
        rd(4'h8, s);
        chk("div_lane", 64'(s), 64'h0000_AB64);
        wr(4'h8, 32'hFFFF_0004, 4'b1111);
        rd(4'h8, s);
        chk("div_rw", 64'(s), 64'h4);

        @(negedge clk);
        bus.ip_data_addr      = BASE;
        bus.ip_data_from_proc = 32'h55;
        bus.ip_data_mask      = 4'b0001;
        bus.ip_data_wr        = 1'b1;
        @(posedge clk);
        #1;
        bus.ip_data_wr = 1'b0;
        @(posedge clk);
        #1;
        chk("latency_hi", 64'(tx), 64'(1));
        fr = {1'b1, 8'h55, 1'b0};
        for (int k = 0; k < 40; k++) begin
            @(posedge clk);
            #1;
            obs[k]  = tx;
            expv[k] = fr[k / 4];
        end
        chk("frame_55", 64'(obs), 64'(expv));
        @(posedge clk);
        #1;
        chk("after_55_tx", 64'(tx), 64'(1));
        rd(4'h4, s);
        chk("after_55_status", 64'(s), 64'h2);

        // Overflow with the serialiser stalled by a long bit period
        wr(4'h8, 32'd1000, 4'b0011);
        for (int i = 0; i < 9; i++) wr(4'h0, $urandom, 4'b0001);
        rd(4'h4, s);
        chk("fifo_full", 64'(s), 64'h5);
        wr(4'h0, 32'hAA, 4'b0001);
        rd(4'h0, s);
        chk("ovf_set", 64'(s), 64'hD);
        wr(4'h4, 32'h8, 4'b0000);
        rd(4'h4, s);
        chk("ovf_mask_keep", 64'(s), 64'hD);
        wr(4'h4, 32'h8, 4'b0001);
        rd(4'h4, s);
        chk("ovf_clear", 64'(s), 64'h5);
        wr(4'hC, 32'hFFFF_FFFF, 4'b1111);
        rd(4'hC, s);
        chk("reserved_wr", 64'(s), 64'h0);

        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        rd(4'h4, s);
        chk("rst2_status", 64'(s), 64'h2);

        // Two frames back to back at DIV=2
        mon_en  = 1'b1;
        mon_div = 2;
        frame_starts.delete();
        wr(4'h8, 32'd2, 4'b0011);
        exp_q.push_back(8'hA5);
        exp_q.push_back(8'h3C);
        wr(4'h0, 32'hA5, 4'b0001);
        wr(4'h0, 32'h3C, 4'b0001);
        wait_idle("b2b_idle", 200);
        chk("b2b_frames", 64'(frame_starts.size()), 64'(2));
        if (frame_starts.size() == 2)
            chk("b2b_gap", 64'(frame_starts[1] - frame_starts[0]), 64'(20));
        chk("b2b_drained", 64'(exp_q.size()), 64'(0));

        // Divisor zero gives one-cycle bits
        wr(4'h8, 32'd0, 4'b0011);
        rd(4'h8, s);
        chk("div_zero_rd", 64'(s), 64'h0);
        mon_div = 1;
        b = 8'($urandom);
        exp_q.push_back(b);
        wr(4'h0, {24'b0, b}, 4'b0001);
        wait_idle("div0_idle", 100);
        chk("div0_drained", 64'(exp_q.size()), 64'(0));

        // Randomised traffic at random bit periods
        for (int it = 0; it < 6; it++) begin
            d = $urandom_range(5, 1);
            wr(4'h8, 32'(d), 4'b0011);
            mon_div = d;
            n = $urandom_range(6, 1);
            for (int j = 0; j < n; j++) begin
                b = 8'($urandom);
                exp_q.push_back(b);
                wr(4'h0, {24'b0, b}, 4'b0001);
                repeat ($urandom_range(3, 0)) @(posedge clk);
            end
            wait_idle("rand_idle", 500);
            chk("rand_drained", 64'(exp_q.size()), 64'(0));
            rd(4'h4, s);
            chk("rand_status", 64'(s), 64'h2);
        end

        // Reset in the middle of a frame
        mon_en = 1'b0;
        wr(4'h8, 32'd4, 4'b0011);
        wr(4'h0, 32'h00, 4'b0001);
        repeat (19) @(posedge clk);
        @(negedge clk);
        chk("mid_frame_low", 64'(tx), 64'(0));
        reset = 1'b1;
        #1;
        chk("async_rst_tx", 64'(tx), 64'(1));
        @(negedge clk);
        reset = 1'b0;
        rd(4'h4, s);
        chk("mid_rst_status", 64'(s), 64'h2);
        rd(4'h8, s);
        chk("mid_rst_div", 64'(s), 64'd868);
        obs = '0;
        for (int k = 0; k < 10; k++) begin
            @(posedge clk);
            #1;
            obs[k] = ~tx;
        end
        chk("mid_rst_quiet", 64'(obs), 64'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
